mem_stage_vec: RTL and testbench

Parametrised successor of the pipeline memory stage. It sits between the ExecuteMemory and MemoryWriteback boundaries. It owns the scalar RAM port and a narrow vector beat port, and sequences each vector load or store as NBEATS = LANES/BEAT_LANES beats. While a vector access is in flight it stalls upstream, then registers one writeback entry per retired instruction with the scalar and vector writeback muxes applied.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_vec_if.sv | 25 ++
 rtl/vector_beat_sequencer.sv | 110 +++++++++++
 rtl/mem_stage_vec.sv | 136 +++++++++++++
 tb/tb_mem_stage_vec.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the vector-capable memory stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {IDLE, VREAD, VWRITE, VDRAIN} beat_state_e;

    localparam logic [1:0] WB_SEL_MEM = 2'b00;

    function automatic int nbeats(input int lanes, input int beat_lanes);
        return lanes / beat_lanes;
    endfunction

endpackage

// File: rtl/mem_stage_vec_if.sv
// RAM-side bus of the memory stage: scalar port a and vector beat port b.
interface mem_stage_vec_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int BEAT_W = 32
);
    logic [ADDR_W-1:0] mem_addr_a;
    logic [DATA_W-1:0] mem_wdata_a;
    logic              mem_wren_a;
    logic [DATA_W-1:0] mem_rdata_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [BEAT_W-1:0] mem_wdata_b;
    logic              mem_wren_b;
    logic [BEAT_W-1:0] mem_rdata_b;

    modport master (
        output mem_addr_a, mem_wdata_a, mem_wren_a, mem_addr_b, mem_wdata_b, mem_wren_b,
        input  mem_rdata_a, mem_rdata_b
    );

    modport slave (
        input  mem_addr_a, mem_wdata_a, mem_wren_a, mem_addr_b, mem_wdata_b, mem_wren_b,
        output mem_rdata_a, mem_rdata_b
    );
endinterface

// File: rtl/vector_beat_sequencer.sv
// Splits one vector load/store into NBEATS port-b beats and produces the stall,
// retire and read-capture strobes that the stage top needs.
module vector_beat_sequencer
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LANES      = 16,
    parameter int LANE_W     = 8,
    parameter int BEAT_LANES = 4,
    parameter int NBEATS     = nbeats(LANES, BEAT_LANES),
    parameter int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    parameter int BEAT_W     = BEAT_LANES * LANE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic                    load,
    input  logic                    store,
    input  logic [ADDR_W-1:0]       base,
    input  logic [LANES*LANE_W-1:0] store_data,
    output logic [ADDR_W-1:0]       addr,
    output logic [BEAT_W-1:0]       wdata,
    output logic                    wren,
    output logic                    stall,
    output logic                    busy,
    output logic                    retire,
    output logic                    capture,
    output logic [CNT_W-1:0]        capture_idx
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    beat_state_e       state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] base_q;
    logic              rd_pending_q;
    logic [CNT_W-1:0]  rd_idx_q;

    logic              accept;
    logic              writing;
    logic              issue;
    logic              last;
    logic [CNT_W-1:0]  issue_idx;
    int                beat_off;

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path can infer a latch.
        accept    = 1'b0;
        writing   = 1'b0;
        issue     = 1'b0;
        issue_idx = '0;
        last      = (count == LAST);
        if (state == IDLE) begin
            // A store on port b wins over a simultaneous load.
            accept  = valid && (load || store) && !reset;
            issue   = accept;
            writing = store;
        end else begin
            issue     = (state == VREAD) || (state == VWRITE);
            writing   = (state == VWRITE);
            issue_idx = count;
        end
        beat_off = int'(issue_idx) * BEAT_W;
    end

    assign addr        = (state == IDLE) ? base : base_q + ADDR_W'(count);
    assign wdata       = store_data[beat_off +: BEAT_W];
    assign wren        = issue && writing && !reset;
    assign stall       = !reset && ((accept && (!store || (NBEATS > 1))) ||
                                    (state == VREAD) || (state == VWRITE && !last));
    assign retire      = !reset && ((state == VDRAIN) || (state == VWRITE && last));
    assign busy        = (state != IDLE);
    assign capture     = rd_pending_q;
    assign capture_idx = rd_idx_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            base_q       <= '0;
            rd_pending_q <= 1'b0;
            rd_idx_q     <= '0;
        end else begin
            rd_pending_q <= issue && !writing;
            rd_idx_q     <= issue_idx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_q <= base;
                        count  <= CNT_W'((NBEATS > 1) ? 1 : 0);
                        if (store) state <= (NBEATS > 1) ? VWRITE : IDLE;
                        else       state <= (NBEATS > 1) ? VREAD : VDRAIN;
                    end
                end
                VREAD, VWRITE: begin
                    if (last) begin
                        state <= (state == VREAD) ? VDRAIN : IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                VDRAIN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_vec.sv
// Pipeline memory stage with a scalar RAM port and a beat-sequenced vector port,
// ending in the MEM/WB writeback register.
module mem_stage_vec
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int LANES      = 16,
    parameter int LANE_W     = 8,
    parameter int BEAT_LANES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_memory,
    input  logic                    wre_memory,
    input  logic                    vector_wre_memory,
    input  logic                    write_memory_enable_a_memory,
    input  logic                    read_memory_a_memory,
    input  logic                    write_memory_enable_b_memory,
    input  logic                    read_memory_b_memory,
    input  logic [ADDR_W-1:0]       srcA_memory,
    input  logic [DATA_W-1:0]       srcB_memory,
    input  logic [LANES*LANE_W-1:0] vector_srcB_memory,
    input  logic [DATA_W-1:0]       alu_result_memory,
    input  logic [LANES*LANE_W-1:0] alu_vector_result_memory,
    input  logic [1:0]              select_writeback_data_mux_memory,
    input  logic [1:0]              select_writeback_vector_data_mux_memory,
    input  logic [4:0]              rd_memory,
    mem_stage_vec_if.master         ram,
    output logic                    stall_memory,
    output logic                    access_error,
    output logic                    wre_writeback,
    output logic                    vector_wre_writeback,
    output logic [4:0]              rd_writeback,
    output logic [DATA_W-1:0]       writeback_data,
    output logic [LANES*LANE_W-1:0] writeback_vector
);

    localparam int VEC_W  = LANES * LANE_W;
    localparam int BEAT_W = BEAT_LANES * LANE_W;
    localparam int NBEATS = nbeats(LANES, BEAT_LANES);
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic             busy;
    logic             vec_retire;
    logic             capture;
    logic [CNT_W-1:0] capture_idx;
    int               cap_off;
    logic             idle_valid;
    logic             a_any;
    logic             b_any;
    logic             retire;

    logic [VEC_W-1:0]  buffer;
    logic [DATA_W-1:0] alu_q;
    logic [VEC_W-1:0]  alu_vec_q;
    logic              data_from_mem_q;
    logic              vec_from_mem_q;

    vector_beat_sequencer #(
        .ADDR_W     (ADDR_W),
        .LANES      (LANES),
        .LANE_W     (LANE_W),
        .BEAT_LANES (BEAT_LANES)
    ) u_seq (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid_memory),
        .load        (read_memory_b_memory),
        .store       (write_memory_enable_b_memory),
        .base        (srcA_memory),
        .store_data  (vector_srcB_memory),
        .addr        (ram.mem_addr_b),
        .wdata       (ram.mem_wdata_b),
        .wren        (ram.mem_wren_b),
        .stall       (stall_memory),
        .busy        (busy),
        .retire      (vec_retire),
        .capture     (capture),
        .capture_idx (capture_idx)
    );

    assign a_any      = write_memory_enable_a_memory || read_memory_a_memory;
    assign b_any      = write_memory_enable_b_memory || read_memory_b_memory;
    assign idle_valid = valid_memory && !busy && !reset;

    assign access_error = idle_valid && ((a_any && b_any) ||
                          (write_memory_enable_a_memory && read_memory_a_memory) ||
                          (write_memory_enable_b_memory && read_memory_b_memory));

    // A mixed a/b instruction is treated as a vector access; the scalar store is dropped.
    assign ram.mem_addr_a  = srcA_memory;
    assign ram.mem_wdata_a = srcB_memory;
    assign ram.mem_wren_a  = idle_valid && write_memory_enable_a_memory && !b_any;

    assign retire  = vec_retire || (idle_valid && !stall_memory);
    assign cap_off = int'(capture_idx) * BEAT_W;

    // NOTE: the assembly buffer is a plain register array, so it can take a reset to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer <= '0;
        end else if (capture) begin
            buffer[cap_off +: BEAT_W] <= ram.mem_rdata_b;
        end
    end

    // Memory-sourced data arrives one cycle after the address, i.e. in the writeback cycle,
    // so the register keeps the select and the mux sits on its output.
    always_ff @(posedge clk) begin
        if (reset) begin
            wre_writeback        <= 1'b0;
            vector_wre_writeback <= 1'b0;
            rd_writeback         <= '0;
            alu_q                <= '0;
            alu_vec_q            <= '0;
            data_from_mem_q      <= 1'b0;
            vec_from_mem_q       <= 1'b0;
        end else if (retire) begin
            wre_writeback        <= wre_memory;
            vector_wre_writeback <= vector_wre_memory;
            rd_writeback         <= rd_memory;
            alu_q                <= alu_result_memory;
            alu_vec_q            <= alu_vector_result_memory;
            data_from_mem_q      <= (select_writeback_data_mux_memory == WB_SEL_MEM);
            vec_from_mem_q       <= (select_writeback_vector_data_mux_memory == WB_SEL_MEM);
        end else begin
            wre_writeback        <= 1'b0;
            vector_wre_writeback <= 1'b0;
        end
    end

    assign writeback_data   = data_from_mem_q ? ram.mem_rdata_a : alu_q;
    assign writeback_vector = vec_from_mem_q ? buffer : alu_vec_q;

endmodule

// File: tb/tb_mem_stage_vec.sv
// Self-checking bench for mem_stage_vec: RAM model, writeback scoreboard, scenario tasks.
module tb_mem_stage_vec;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_memory, wre_memory, vector_wre_memory;
    logic         write_memory_enable_a_memory, read_memory_a_memory;
    logic         write_memory_enable_b_memory, read_memory_b_memory;
    logic [15:0]  srcA_memory;
    logic [7:0]   srcB_memory, alu_result_memory;
    logic [127:0] vector_srcB_memory, alu_vector_result_memory;
    logic [1:0]   select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory;
    logic [4:0]   rd_memory;
    logic         stall_memory, access_error, wre_writeback, vector_wre_writeback;
    logic [4:0]   rd_writeback;
    logic [7:0]   writeback_data;
    logic [127:0] writeback_vector;

    always #5 clk = ~clk;

    mem_stage_vec_if bus ();

    mem_stage_vec dut (
        .clk                                     (clk),
        .reset                                   (reset),
        .valid_memory                            (valid_memory),
        .wre_memory                              (wre_memory),
        .vector_wre_memory                       (vector_wre_memory),
        .write_memory_enable_a_memory            (write_memory_enable_a_memory),
        .read_memory_a_memory                    (read_memory_a_memory),
        .write_memory_enable_b_memory            (write_memory_enable_b_memory),
        .read_memory_b_memory                    (read_memory_b_memory),
        .srcA_memory                             (srcA_memory),
        .srcB_memory                             (srcB_memory),
        .vector_srcB_memory                      (vector_srcB_memory),
        .alu_result_memory                       (alu_result_memory),
        .alu_vector_result_memory                (alu_vector_result_memory),
        .select_writeback_data_mux_memory        (select_writeback_data_mux_memory),
        .select_writeback_vector_data_mux_memory (select_writeback_vector_data_mux_memory),
        .rd_memory                               (rd_memory),
        .ram                                     (bus),
        .stall_memory                            (stall_memory),
        .access_error                            (access_error),
        .wre_writeback                           (wre_writeback),
        .vector_wre_writeback                    (vector_wre_writeback),
        .rd_writeback                            (rd_writeback),
        .writeback_data                          (writeback_data),
        .writeback_vector                        (writeback_vector)
    );

    // RAM model: one-cycle read latency on both ports.
    logic [7:0]  ram_a [65536];
    logic [31:0] ram_b [65536];
    always @(posedge clk) begin
        if (bus.mem_wren_a) ram_a[bus.mem_addr_a] <= bus.mem_wdata_a;
        bus.mem_rdata_a <= ram_a[bus.mem_addr_a];
        if (bus.mem_wren_b) ram_b[bus.mem_addr_b] <= bus.mem_wdata_b;
        bus.mem_rdata_b <= ram_b[bus.mem_addr_b];
    end

    typedef struct {
        logic [4:0]   rd;
        logic         is_vec;
        logic [7:0]   data;
        logic [127:0] vec;
    } wb_t;

    wb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    always @(negedge clk) begin
        wb_t e;
        if (reset === 1'b0 && (wre_writeback === 1'b1 || vector_wre_writeback === 1'b1)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected rd=%0d wre=%b vwre=%b required=no writeback",
                         rd_writeback, wre_writeback, vector_wre_writeback);
            end else begin
                e = sb_q.pop_front();
                if (wre_writeback !== !e.is_vec || vector_wre_writeback !== e.is_vec ||
                    rd_writeback !== e.rd ||
                    (e.is_vec ? (writeback_vector !== e.vec) : (writeback_data !== e.data))) begin
                    bad++;
                    $display("FAIL sb_entry rd=%0d data=%h vec=%h required rd=%0d data=%h vec=%h vecop=%b",
                             rd_writeback, writeback_data, writeback_vector, e.rd, e.data, e.vec, e.is_vec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_memory = 0; wre_memory = 0; vector_wre_memory = 0;
        write_memory_enable_a_memory = 0; read_memory_a_memory = 0;
        write_memory_enable_b_memory = 0; read_memory_b_memory = 0;
        srcA_memory = '0; srcB_memory = '0; vector_srcB_memory = '0;
        alu_result_memory = '0; alu_vector_result_memory = '0;
        select_writeback_data_mux_memory = 2'b00;
        select_writeback_vector_data_mux_memory = 2'b00;
        rd_memory = '0;
    endtask

    // Drives a vector store for its four beats; leaves inputs set at the start of T+4.
    task automatic vector_store(input logic [15:0] base, input logic [127:0] v, input logic with_a);
        clear_inputs();
        valid_memory = 1; write_memory_enable_b_memory = 1;
        srcA_memory = base; vector_srcB_memory = v;
        if (with_a) begin write_memory_enable_a_memory = 1; srcB_memory = 8'hAA; end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ea;
            logic [31:0] ed;
            ea = base + 16'(k);
            ed = v[k*32 +: 32];
            @(negedge clk);
            total++; if (bus.mem_wren_b !== 1'b1) begin bad++; $display("FAIL vst_wren beat=%0d got=%b want=1", k, bus.mem_wren_b); end
            total++; if (bus.mem_addr_b !== ea) begin bad++; $display("FAIL vst_addr beat=%0d got=%h want=%h", k, bus.mem_addr_b, ea); end
            total++; if (bus.mem_wdata_b !== ed) begin bad++; $display("FAIL vst_wdata beat=%0d got=%h want=%h", k, bus.mem_wdata_b, ed); end
            total++; if (stall_memory !== (k < 3)) begin bad++; $display("FAIL vst_stall beat=%0d got=%b want=%b", k, stall_memory, k < 3); end
            total++; if (access_error !== (with_a && k == 0)) begin bad++; $display("FAIL vst_error beat=%0d got=%b want=%b", k, access_error, with_a && k == 0); end
            total++; if (bus.mem_wren_a !== 1'b0) begin bad++; $display("FAIL vst_wren_a beat=%0d got=%b want=0", k, bus.mem_wren_a); end
            step();
        end
    endtask

    // Vector load with vector writeback; returns at the start of T+6.
    task automatic vector_load(input logic [15:0] base, input logic [1:0] vsel,
                               input logic [127:0] alu_v, input logic [127:0] exp_v,
                               input logic [4:0] rd_i);
        wb_t e;
        clear_inputs();
        valid_memory = 1; read_memory_b_memory = 1; srcA_memory = base;
        vector_wre_memory = 1; rd_memory = rd_i;
        select_writeback_vector_data_mux_memory = vsel; alu_vector_result_memory = alu_v;
        e.rd = rd_i; e.is_vec = 1'b1; e.data = '0; e.vec = exp_v;
        sb_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ea;
            ea = base + 16'(k);
            @(negedge clk);
            total++; if (stall_memory !== 1'b1) begin bad++; $display("FAIL vld_stall beat=%0d got=%b want=1", k, stall_memory); end
            total++; if (bus.mem_addr_b !== ea) begin bad++; $display("FAIL vld_addr beat=%0d got=%h want=%h", k, bus.mem_addr_b, ea); end
            total++; if (bus.mem_wren_b !== 1'b0) begin bad++; $display("FAIL vld_wren beat=%0d got=%b want=0", k, bus.mem_wren_b); end
            step();
        end
        @(negedge clk);
        total++; if (stall_memory !== 1'b0) begin bad++; $display("FAIL vld_drain_stall got=%b want=0", stall_memory); end
        total++; if (vector_wre_writeback !== 1'b0) begin bad++; $display("FAIL vld_bubble got=%b want=0", vector_wre_writeback); end
        step();
        clear_inputs();
        @(negedge clk);
        total++; if (vector_wre_writeback !== 1'b1) begin bad++; $display("FAIL vld_wb_wre got=%b want=1", vector_wre_writeback); end
        total++; if (writeback_vector !== exp_v) begin bad++; $display("FAIL vld_wb_vec got=%h want=%h", writeback_vector, exp_v); end
        step();
    endtask

    task automatic scalar_load(input logic [15:0] a, input logic [1:0] sel,
                               input logic [7:0] alu, input logic [7:0] exp_d, input logic [4:0] rd_i);
        wb_t e;
        clear_inputs();
        valid_memory = 1; read_memory_a_memory = 1; srcA_memory = a; wre_memory = 1;
        rd_memory = rd_i; select_writeback_data_mux_memory = sel; alu_result_memory = alu;
        e.rd = rd_i; e.is_vec = 1'b0; e.data = exp_d; e.vec = '0;
        sb_q.push_back(e);
        @(negedge clk);
        total++; if (stall_memory !== 1'b0) begin bad++; $display("FAIL sld_stall got=%b want=0", stall_memory); end
        step();
        clear_inputs();
        @(negedge clk);
        total++; if (wre_writeback !== 1'b1) begin bad++; $display("FAIL sld_wre got=%b want=1", wre_writeback); end
        total++; if (writeback_data !== exp_d) begin bad++; $display("FAIL sld_data got=%h want=%h", writeback_data, exp_d); end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        valid_memory = 1; write_memory_enable_a_memory = 1; write_memory_enable_b_memory = 1;
        repeat (2) step();
        @(negedge clk);
        total++; if (stall_memory !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_memory); end
        total++; if ({bus.mem_wren_a, bus.mem_wren_b} !== 2'b00) begin bad++; $display("FAIL rst_wren got=%b want=00", {bus.mem_wren_a, bus.mem_wren_b}); end
        total++; if ({wre_writeback, vector_wre_writeback, access_error} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {wre_writeback, vector_wre_writeback, access_error}); end
        total++; if ({rd_writeback, writeback_data, writeback_vector} !== '0) begin bad++; $display("FAIL rst_wb got=%h/%h/%h want=0", rd_writeback, writeback_data, writeback_vector); end
        clear_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_scalar();
        clear_inputs();
        valid_memory = 1; write_memory_enable_a_memory = 1; srcA_memory = 16'h0010; srcB_memory = 8'h5A;
        @(negedge clk);
        total++; if (bus.mem_wren_a !== 1'b1) begin bad++; $display("FAIL sst_wren got=%b want=1", bus.mem_wren_a); end
        total++; if (bus.mem_addr_a !== 16'h0010) begin bad++; $display("FAIL sst_addr got=%h want=0010", bus.mem_addr_a); end
        total++; if (bus.mem_wdata_a !== 8'h5A) begin bad++; $display("FAIL sst_wdata got=%h want=5a", bus.mem_wdata_a); end
        total++; if (stall_memory !== 1'b0) begin bad++; $display("FAIL sst_stall got=%b want=0", stall_memory); end
        step();
        scalar_load(16'h0010, 2'b00, 8'h00, 8'h5A, 5'd3);
        scalar_load(16'h0010, 2'b01, 8'h77, 8'h77, 5'd2);
    endtask

    task automatic test_vector();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(15 - i);
        vector_store(16'h0020, v, 1'b0);
        clear_inputs();
        @(negedge clk);
        total++; if (bus.mem_wren_b !== 1'b0) begin bad++; $display("FAIL vst_end_wren got=%b want=0", bus.mem_wren_b); end
        step();
        vector_load(16'h0020, 2'b00, '0, v, 5'd7);
    endtask

    task automatic test_wrap();
        logic [127:0] w;
        w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vector_store(16'hFFFE, w, 1'b0);
        clear_inputs();
        step();
        vector_load(16'hFFFE, 2'b00, '0, w, 5'd9);
    endtask

    task automatic test_reset_mid_load();
        clear_inputs();
        valid_memory = 1; read_memory_b_memory = 1; srcA_memory = 16'h0020;
        vector_wre_memory = 1; rd_memory = 5'd12;
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.mem_wren_b !== 1'b0) begin bad++; $display("FAIL mid_rst_wren got=%b want=0", bus.mem_wren_b); end
        step();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        total++; if (stall_memory !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%b want=0", stall_memory); end
        total++; if ({bus.mem_wren_a, bus.mem_wren_b, access_error, wre_writeback, vector_wre_writeback} !== 5'b0) begin
            bad++; $display("FAIL mid_rst_flags got=%b want=00000", {bus.mem_wren_a, bus.mem_wren_b, access_error, wre_writeback, vector_wre_writeback});
        end
        total++; if ({writeback_data, writeback_vector} !== '0) begin bad++; $display("FAIL mid_rst_wb got=%h/%h want=0", writeback_data, writeback_vector); end
        repeat (4) step();
        scalar_load(16'h0010, 2'b00, 8'h00, 8'h5A, 5'd4);
    endtask

    task automatic test_illegal();
        logic [127:0] w2;
        w2 = 128'hA5A5_0001_C3C3_0002_F00F_0003_1234_0004;
        vector_store(16'h0030, w2, 1'b1);
        clear_inputs();
        step();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ed;
            ed = w2[k*32 +: 32];
            total++; if (ram_b[16'h0030 + k] !== ed) begin bad++; $display("FAIL ill_stored beat=%0d got=%h want=%h", k, ram_b[16'h0030 + k], ed); end
        end
        total++; if (ram_a[16'h0030] !== 8'h00) begin bad++; $display("FAIL ill_scalar_suppressed got=%h want=00", ram_a[16'h0030]); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] u;
        u = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        vector_store(16'h0040, u, 1'b0);
        vector_load(16'h0040, 2'b00, '0, u, 5'd10);
    endtask

    task automatic test_alu();
        vector_load(16'h0020, 2'b01, 128'h1, 128'h1, 5'd13);
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_wrap();
        test_reset_mid_load();
        test_illegal();
        test_back_to_back();
        test_alu();
        repeat (3) step();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d entries want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
